// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor range, door state encoding and one-hot helper for the call panel
package elevator_pkg;
   localparam int NFLOORS_DEF = 3;
   localparam int FLOOR_LO    = 1;
   localparam int MAX_FLOORS  = 32;
   typedef enum logic {
      DOOR_IDLE = 1'b0,
      DOOR_OPEN = 1'b1
   } door_state_t;
   // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
   function automatic logic onehot_valid(input logic [MAX_FLOORS-1:0] i_v);
      return (i_v != '0) && ((i_v & (i_v - MAX_FLOORS'(1))) == '0);
   endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stability counter and registered rising-edge press pulse
//   clk, RESET : clock and asynchronous active-high reset
//   i_btn      : raw asynchronous, bounce-prone button
//   o_press    : one-cycle pulse per debounced press (releases give nothing)
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic RESET,
   input  logic i_btn,
   output logic o_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic          r_s1, r_s2, r_level, r_level_d, r_press;
   logic [CW-1:0] r_cnt;
   logic          w_mismatch, w_done;
   assign w_mismatch = r_s2 ^ r_level;
   // The DEBOUNCE_CYCLES-th consecutive mismatch flips the level on this edge.
   assign w_done = w_mismatch && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_s1      <= i_btn;
         r_s2      <= r_s1;
         r_cnt     <= (!w_mismatch || w_done) ? '0 : r_cnt + CW'(1);
         r_level   <= w_done ? r_s2 : r_level;
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end
   assign o_press = r_press;
endmodule

// File: rtl/elevator_call_panel.sv
// elevator_call_panel: debounced hall calls held as pending requests, door timer and fault flag
//   clk, RESET     : clock and asynchronous active-high reset
//   i_btn          : raw hall buttons, one per floor
//   i_car_floor    : one-hot car floor (zero or several bits = no current floor)
//   i_car_moving   : car between floors or travelling
//   o_req          : pending calls / call lamps
//   o_served       : one-cycle pulse when a pending call is cleared by service
//   o_door_open    : door open command
//   o_door_fault   : sticky, car moved while the door was open
module elevator_call_panel
   import elevator_pkg::*;
#(
   parameter int NFLOORS         = NFLOORS_DEF,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DOOR_CYCLES     = 8
) (
   input  logic                    clk,
   input  logic                    RESET,
   input  logic [NFLOORS:FLOOR_LO] i_btn,
   input  logic [NFLOORS:FLOOR_LO] i_car_floor,
   input  logic                    i_car_moving,
   output logic [NFLOORS:FLOOR_LO] o_req,
   output logic [NFLOORS:FLOOR_LO] o_served,
   output logic                    o_door_open,
   output logic                    o_door_fault
);
   localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(DOOR_CYCLES - 1);
   door_state_t             r_state, w_state_nx;
   logic [TW-1:0]           r_timer, w_timer_nx;
   logic [NFLOORS:FLOOR_LO] r_req, w_req_nx, r_served, w_served_nx;
   logic [NFLOORS:FLOOR_LO] w_press, w_cur, w_stop, w_clear, w_block;
   logic                    r_fault, w_fault_nx, w_valid;
   for (genvar g = FLOOR_LO; g <= NFLOORS; g++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .RESET  (RESET),
         .i_btn  (i_btn[g]),
         .o_press(w_press[g])
      );
   end
   assign w_valid = onehot_valid(MAX_FLOORS'(i_car_floor));
   assign w_cur   = w_valid ? i_car_floor : '0;
   assign w_stop  = (w_valid && !i_car_moving) ? i_car_floor : '0;
   always_comb begin
      w_state_nx  = r_state;
      w_timer_nx  = r_timer;
      w_served_nx = '0;
      w_fault_nx  = r_fault;
      w_clear     = '0;
      w_block     = '0;
      if (r_state == DOOR_IDLE) begin
         // A press at the stop floor is consumed by the opening, never latched.
         if (|(w_stop & (r_req | w_press))) begin
            w_state_nx  = DOOR_OPEN;
            w_timer_nx  = TMAX;
            w_clear     = w_stop;
            w_served_nx = w_stop & r_req;
         end
      end else begin
         // Presses at the floor the door is open on only extend the open time.
         w_block = w_cur;
         if (i_car_moving) begin
            w_fault_nx = 1'b1;
            w_state_nx = DOOR_IDLE;
         end else if (|(w_press & w_cur)) begin
            w_timer_nx = TMAX;
         end else if (r_timer == '0) begin
            w_state_nx = DOOR_IDLE;
         end else begin
            w_timer_nx = r_timer - TW'(1);
         end
      end
      w_req_nx = (r_req | (w_press & ~w_block)) & ~w_clear;
   end
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_state  <= DOOR_IDLE;
         r_timer  <= '0;
         r_req    <= '0;
         r_served <= '0;
         r_fault  <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_timer  <= w_timer_nx;
         r_req    <= w_req_nx;
         r_served <= w_served_nx;
         r_fault  <= w_fault_nx;
      end
   end
   assign o_req        = r_req;
   assign o_served     = r_served;
   assign o_door_open  = (r_state == DOOR_OPEN);
   assign o_door_fault = r_fault;
endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Request side of the elevator: the initiator that produces the call vector the car controller consumes.
- Synchronizes and debounces raw floor buttons, then holds each call as a pending request until the car serves that floor.
- Runs the door-open timer at each service stop, and drives the call lamps, served pulses and a door fault flag.

Parameters:
NFLOORS, 3, number of floors; floors indexed NFLOORS..1
DEBOUNCE_CYCLES, 4, consecutive stable samples before a debounced level changes (>=1)
DOOR_CYCLES, 8, clock cycles the door stays open per service (>=1)

Ports:
clk  input  1  clock
RESET  input  1  reset; asynchronous, active-high
btn  input  [NFLOORS:1]  raw hall buttons, asynchronous, bounce-prone
car_floor  input  [NFLOORS:1]  one-hot current car floor from the car controller
car_moving  input  1  car between floors or travelling
req  output  [NFLOORS:1]  pending calls to the car controller; also drives the call lamps
served  output  [NFLOORS:1]  one-cycle pulse when a floor's call is cleared
door_open  output  1  door open command
door_fault  output  1  sticky: car_moving asserted while the door is open

Behaviour:
- Reset: reset is RESET, asynchronous, active-high; clock is clk. On RESET, these all go to 0 immediately: sync flops, debounced levels, debounce counters, req, served, door_open, door_fault. Door FSM goes to DOOR_IDLE.
- Synchronizer: 2 flops per bit.
- Debounce, per bit:
  - A counter compares the synchronized input with the debounced level.
  - On mismatch the counter increments; on match it clears.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press event: one-cycle pulse on a debounced rising edge. Releases produce nothing.
- Latency: btn held high from a sampling edge k gives req high after edge k+DEBOUNCE_CYCLES+3, exactly.
- Floor validity: car_floor is valid only when exactly one bit is set. Zero or multiple bits means no current floor; no service and no door activity.
- "Stopped at f": car_floor valid, with bit f set, and car_moving=0.
- Door FSM (registered outputs):
  - DOOR_IDLE: door_open=0. Go to DOOR_OPEN when stopped at f and (req[f]=1 or press[f]=1). On that transition: clear req[f], pulse served[f] only if req[f] was 1, load the timer with DOOR_CYCLES-1.
  - DOOR_OPEN: door_open=1. The timer decrements each cycle. At timer=0, go to DOOR_IDLE, so the door is open for exactly DOOR_CYCLES cycles.
  - A press at the current floor while in DOOR_OPEN reloads the timer and never sets req.
  - car_moving=1 in DOOR_OPEN: set door_fault, go to DOOR_IDLE. door_fault is cleared only by RESET.
- Pending register, per floor i:
  - Set on press[i] unless it is consumed by service.
  - Cleared only by service.
  - Press[i] in the same cycle as service of floor i: clear wins, and the door opens.
  - Presses on other floors in the same cycle set normally.
  - Repeated presses of an already pending floor cause no change.
- Simultaneous presses on all floors: all req bits set in the same cycle.
- The car controller chooses direction from req. This block never drives direction.

Decomposition:
- Shared package elevator_pkg holds:
  - NFLOORS default and the floor index range;
  - door state encoding DOOR_IDLE=1'b0, DOOR_OPEN=1'b1;
  - a one-hot-valid function.
- Sub-module button_debounce: 1-bit 2-flop sync, debounce counter and rising-edge pulse, parameterized by DEBOUNCE_CYCLES, instantiated NFLOORS times.
- The top level holds the pending register, door FSM, timer and fault flag.

Test Plan:
- Clean press: btn[3] high for 20 cycles, car_moving=1 → req=3'b100 exactly DEBOUNCE_CYCLES+3 edges after the first sample; served=0, door_open=0.
- Bounce rejection: btn[2] toggling every 2 cycles for 30 cycles (DEBOUNCE_CYCLES=4) → req stays 3'b000; then held high → req[2]=1.
- Service: req=3'b110, car stops with car_floor=3'b010 → next edge req=3'b100, served=3'b010 for 1 cycle, door_open=1 for exactly 8 cycles.
- Press at open door: door open at floor 1, btn[1] debounced press mid-timer → timer reloads, door_open extends to 8 cycles after the press, req[1] stays 0, no served pulse.
- Fault and invalid floor: car_floor=3'b011 with req=3'b011 → no service. Then valid floor 1, door opens, car_moving=1 → door_fault=1, door_open=0; door_fault holds until RESET.
- Async reset mid-operation: RESET pulsed during DOOR_OPEN with req=3'b101 → all outputs 0 immediately, no clock edge required.
